// File: rtl/state_unloader.sv
// Unloads a captured cipher state as a stream of WORD-bit words, MSB word first,
// with a byte-keep mask on the final word and a one-cycle done pulse afterwards.
module state_unloader #(
  parameter  int WIDTH = 128,
  parameter  int WORD  = 32,
  parameter  int NW    = WIDTH / WORD,
  localparam int CW    = $clog2(NW + 1),
  localparam int KW    = WORD / 8,
  localparam int LBW   = $clog2(KW) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] state_in,
  input  logic [CW-1:0]    nwords,
  input  logic [LBW-1:0]   last_bytes,
  input  logic             m_ready,
  output logic [WORD-1:0]  m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic [KW-1:0]    m_keep,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Upper lb byte lanes enabled; zero or out-of-range lb means a full word.
  function automatic logic [KW-1:0] keep_mask(input logic [LBW-1:0] lb);
    logic [KW-1:0] m;
    if ((lb == {LBW{1'b0}}) || (int'(lb) >= KW)) begin
      m = {KW{1'b1}};
    end else begin
      m = ~({KW{1'b1}} >> lb);
    end
    return m;
  endfunction

  function automatic logic [WORD-1:0] byte_mask(input logic [KW-1:0] k);
    logic [WORD-1:0] m;
    m = {WORD{1'b0}};
    for (int i = 0; i < KW; i++) begin
      m[i*8 +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LBW-1:0]   lb_q, lb_d;
  logic [WORD-1:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [KW-1:0]    keep_q, keep_d;
  logic             done_q, done_d;

  // Next-state: capture on load in IDLE, shift out one word per accepted transfer.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    lb_d    = lb_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d    = state_in;
          lb_d    = last_bytes;
          state_d = SEND;
          if ((nwords == {CW{1'b0}}) || (nwords > CW'(NW))) begin
            cnt_d = CW'(NW);
          end else begin
            cnt_d = nwords;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (m_ready) begin
          sr_d  = sr_q << WORD;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output words are precomputed from next state so every output leaves a flop.
  always_comb begin
    valid_d = 1'b0;
    last_d  = 1'b0;
    keep_d  = {KW{1'b0}};
    data_d  = {WORD{1'b0}};
    if (state_d == SEND) begin
      valid_d = 1'b1;
      last_d  = (cnt_d == CW'(1));
      if (last_d) begin
        keep_d = keep_mask(lb_d);
      end else begin
        keep_d = {KW{1'b1}};
      end
      data_d = sr_d[WIDTH-1 -: WORD] & byte_mask(keep_d);
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      lb_q    <= {LBW{1'b0}};
      data_q  <= {WORD{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      keep_q  <= {KW{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      lb_q    <= lb_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
      done_q  <= done_d;
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign m_keep  = keep_q;
  assign done    = done_q;
  assign busy    = (state_q == SEND);

endmodule
